// File: rtl/oled_text_arb_pkg.sv
// Shared types and constants for the OLED text-buffer arbiter.
package oled_text_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0]  CHAR_SPACE = 8'h20;
    localparam int unsigned ADDR_W     = 6;

endpackage

// File: rtl/oled_text_arb_rr_arb2.sv
// Two-way write arbiter; alternates on contention, or fixed req0 priority
// when OLED_TEXT_ARB_FIXPRI_EN is defined.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

`ifdef OLED_TEXT_ARB_FIXPRI_EN
    always_comb begin
        o_grant = '0;
        if (i_en && !rst) begin
            if (i_valid[0])      o_grant = 2'b01;
            else if (i_valid[1]) o_grant = 2'b10;
        end
    end
`else
    logic r_ptr;

    always_comb begin
        o_grant = '0;
        if (i_en && !rst) begin
            if (i_valid == 2'b11) o_grant = r_ptr ? 2'b10 : 2'b01;
            else                  o_grant = i_valid;
        end
    end

    // Pointer always hands priority to the side that was not just served.
    always_ff @(posedge clk) begin
        if (rst)             r_ptr <= 1'b0;
        else if (o_grant[0]) r_ptr <= 1'b1;
        else if (o_grant[1]) r_ptr <= 1'b0;
    end
`endif

endmodule

// File: rtl/oled_text_arb.sv
// Arbitrated 64-cell text buffer with bulk clear and frame-synchronous shadow.
// Optional macro OLED_TEXT_ARB_FIXPRI_EN selects fixed priority in rr_arb2.
module oled_text_arb
    import oled_text_arb_pkg::*;
#(
    parameter int unsigned CHARS    = 64,
    parameter logic [7:0]  CLR_CHAR = CHAR_SPACE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_char,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_char,
    output logic              req1_ready,
    input  logic              clr,
    input  logic              print_fin,
    output logic [CHARS*8-1:0] char_data,
    output logic              dirty,
    output logic              busy
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_work   [CHARS];
    logic [7:0]        r_shadow [CHARS];
    logic              r_dirty;

    logic              w_busy, w_arb_en, w_sweep_last, w_wr_en, w_commit;
    logic [1:0]        w_grant;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_wr_char;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_arb_en),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    assign w_sweep_last = (r_cnt == ADDR_W'(CHARS - 1));
    assign w_wr_en      = |w_grant;
    assign w_wr_addr    = w_grant[1] ? req1_addr : req0_addr;
    assign w_wr_char    = w_grant[1] ? req1_char : req0_char;
    assign w_commit     = print_fin && r_dirty && !w_busy;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (clr)          w_next = ST_CLEAR;
            ST_CLEAR: if (w_sweep_last) w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state == ST_CLEAR);
        w_arb_en = (r_state == ST_IDLE);
    end

    // Shadow copies the pre-edge working buffer, so a same-edge write stays dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work   <= '{default: CLR_CHAR};
            r_shadow <= '{default: CLR_CHAR};
            r_dirty  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_commit) r_shadow <= r_work;
            if (w_busy) begin
                r_work[r_cnt] <= CLR_CHAR;
                r_cnt         <= r_cnt + 1'b1;
                if (w_sweep_last) r_dirty <= 1'b1;
            end else begin
                r_cnt <= '0;
                if (w_wr_en) begin
                    r_work[w_wr_addr] <= w_wr_char;
                    r_dirty           <= 1'b1;
                end else if (w_commit) begin
                    r_dirty <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < CHARS; g++) begin : g_pack
        assign char_data[(CHARS-1-g)*8 +: 8] = r_shadow[g];
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign dirty      = r_dirty;
    assign busy       = w_busy;

endmodule

// File: tb/tb_oled_text_arb.sv
// Directed self-checking bench for oled_text_arb.
module tb_oled_text_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0]   req0_addr, req1_addr;
    logic [7:0]   req0_char, req1_char;
    logic         clr, print_fin, dirty, busy;
    logic [511:0] char_data;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_work [64];
    logic [7:0] exp_shad [64];

    always #5 clk = ~clk;

    oled_text_arb #(.CHARS(64), .CLR_CHAR(8'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_char  (req0_char),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_char  (req1_char),
        .req1_ready (req1_ready),
        .clr        (clr),
        .print_fin  (print_fin),
        .char_data  (char_data),
        .dirty      (dirty),
        .busy       (busy)
    );

    function automatic logic [511:0] shad_vec();
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[(63-i)*8 +: 8] = exp_shad[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_model();
        for (int i = 0; i < 64; i++) exp_shad[i] = exp_work[i];
    endtask

    task automatic model_fill();
        for (int i = 0; i < 64; i++) begin
            exp_work[i] = 8'h20;
            exp_shad[i] = 8'h20;
        end
    endtask

    initial begin
        logic e0;
        int   n0, n1, nb;

        model_fill();
        rst = 1'b1; clr = 1'b0; print_fin = 1'b0;
        req0_valid = 1'b1; req0_addr = '0; req0_char = 8'h00;
        req1_valid = 1'b1; req1_addr = '0; req1_char = 8'h00;
        repeat (3) step();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_data", char_data, shad_vec());
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Single write then commit three cycles later
        req0_valid = 1'b1; req0_addr = 6'd0; req0_char = 8'h41;
        #1 chk("w0_ready", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        exp_work[0] = 8'h41;
        chk("w0_dirty_set", dirty, 1);
        chk("w0_not_yet", char_data, shad_vec());
        step(); step();
        print_fin = 1'b1; step(); print_fin = 1'b0;
        commit_model();
        chk("w0_dirty_clr", dirty, 0);
        chk("w0_data", char_data, shad_vec());

        // Lone req1 write moves the pointer back to requester 0
        req1_valid = 1'b1; req1_addr = 6'd7; req1_char = 8'h37;
        #1 chk("w1_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        exp_work[7] = 8'h37;

        // Contention for four cycles
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_addr = 6'd5; req0_char = 8'h61;
        req1_valid = 1'b1; req1_addr = 6'd6; req1_char = 8'h71;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef OLED_TEXT_ARB_FIXPRI_EN
            e0 = 1'b1;
`else
            e0 = (k % 2 == 0);
`endif
            chk($sformatf("arb%0d_r0", k), req0_ready, e0);
            chk($sformatf("arb%0d_r1", k), req1_ready, !e0);
            step();
            if (e0) begin
                exp_work[5] = req0_char; n0++; req0_char = 8'(8'h61 + n0);
            end else begin
                exp_work[6] = req1_char; n1++; req1_char = 8'(8'h71 + n1);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        print_fin = 1'b1; step(); print_fin = 1'b0;
        commit_model();
        chk("arb_data", char_data, shad_vec());

        // Write cell 63, then clear sweep with mid-sweep print_fin
        req0_valid = 1'b1; req0_addr = 6'd63; req0_char = 8'h58;
        step();
        exp_work[63] = 8'h58;
        req0_valid = 1'b0;
        clr = 1'b1; step(); clr = 1'b0;
        req0_valid = 1'b1;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            chk("clr_ready0", req0_ready, 0);
            if (nb == 20) begin
                print_fin = 1'b1; step(); print_fin = 1'b0;
                chk("clr_midfin", char_data, shad_vec());
            end else begin
                step();
            end
            nb++;
        end
        req0_valid = 1'b0;
        chk("clr_len", 32'(nb), 64);
        chk("clr_dirty", dirty, 1);
        for (int i = 0; i < 64; i++) exp_work[i] = 8'h20;
        print_fin = 1'b1; step(); print_fin = 1'b0;
        commit_model();
        chk("clr_data", char_data, shad_vec());
        chk("clr_cell63", char_data[7:0], 8'h20);

        // Commit coinciding with a granted write
        req0_valid = 1'b1; req0_addr = 6'd11; req0_char = 8'h4C;
        step();
        exp_work[11] = 8'h4C;
        req0_addr = 6'd10; req0_char = 8'h4B; print_fin = 1'b1;
        step();
        commit_model();
        exp_work[10] = 8'h4B;
        req0_valid = 1'b0; print_fin = 1'b0;
        chk("coin_data", char_data, shad_vec());
        chk("coin_dirty", dirty, 1);
        print_fin = 1'b1; step(); print_fin = 1'b0;
        commit_model();
        chk("coin_next", char_data, shad_vec());
        chk("coin_dirty_clr", dirty, 0);

        // Reset on cycle 30 of a clear sweep
        clr = 1'b1; step(); clr = 1'b0;
        repeat (29) step();
        chk("rclr_busy_pre", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        model_fill();
        chk("rclr_busy", busy, 0);
        chk("rclr_dirty", dirty, 0);
        chk("rclr_data", char_data, shad_vec());
        req1_valid = 1'b1; req1_addr = 6'd2; req1_char = 8'h5A;
        #1 chk("rclr_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        exp_work[2] = 8'h5A;
        chk("rclr_dirty_set", dirty, 1);
        print_fin = 1'b1; step(); print_fin = 1'b0;
        commit_model();
        chk("rclr_commit", char_data, shad_vec());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
